updown_count_checker: RTL and testbench
=======================================

# updown_count_checker

- Synchronous monitor for the output of the 4-bit up/down counter.
- Samples the counter value, infers count direction, and locks once consecutive unit steps agree.
- Afterwards flags any sample that is not a legal ±1 step; a clean direction reversal is reported separately from errors.
- Sits beside the counter in the counter's test and integration environments as the reading end of its count stream.

## Interface
Parameters:
- W, 4, counter width in bits; legal range 2..16.
- LOCK_N, 3, consecutive same-direction unit steps required to lock; legal range 1..15.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- en  input  1  sample strobe; q_in is consumed on an edge where en=1.
- q_in  input  W  counter value under observation.
- dir  output  1  current direction: 1=up, 0=down.
- locked  output  1  high while in LOCK state.
- err  output  1  one-cycle pulse: illegal step seen while locked.
- rev  output  1  one-cycle pulse: legal opposite-direction step seen while locked.
- err_cnt  output  ERR_W  number of err pulses since reset; saturates at all-ones.

## Operation
- Registers:
  - prev (W bits).
  - state.
  - run (4 bits).
  - All outputs registered.
- Step definition: delta = (q_in − prev) mod 2^W.
  - UP when delta==1; DOWN when delta==2^W−1; STALL when delta==0; otherwise JUMP.
  - Wrap is legal: 15→0 is UP and 0→15 is DOWN (W=4).
- On every edge with en=1, prev ← q_in after evaluation. With en=0, no register changes, and err/rev are driven 0.
- States: EMPTY, ACQ, LOCK.
  - EMPTY:
    - Any sample → ACQ.
    - run=0; no step is evaluated.
  - ACQ, UP/DOWN step of direction d:
    - If run>0 and d==dir, run ← run+1; else dir ← d and run ← 1.
    - If the new run value equals LOCK_N → LOCK, locked ← 1.
  - ACQ, STALL or JUMP: run ← 0; dir unchanged; no err (errors are counted only while locked).
  - LOCK:
    - Step matching dir: no change.
    - Step opposite to dir: dir ← ~dir, rev pulse, remain LOCK.
    - STALL or JUMP: err pulse, err_cnt increments (saturating), locked ← 0, run ← 0, → ACQ.
- The run counter saturates at LOCK_N; it never exceeds LOCK_N.

## Timing
- Reset values:
  - state=EMPTY, prev=0, run=0.
  - dir=1, locked=0, err=0, rev=0, err_cnt=0.
- Reset has priority over en on the same edge. Reset mid-LOCK drops locked on that edge; the next sample is treated as the first (no step evaluated).
- Latency: a sample taken on edge k updates dir/locked/err/rev/err_cnt as of edge k, visible in cycle k+1. err and rev are high for exactly one cycle per offending sample.
- Lock timing: first sample plus LOCK_N unit steps → locked rises on the edge of sample LOCK_N+1.
- Consecutive errors: each illegal sample in LOCK produces err. After the first error the block is in ACQ, so further illegal samples produce no err until it relocks.
- err_cnt holds at 2^ERR_W−1 once saturated; err still pulses.
- Gaps in en are transparent: the step is measured against the last sampled value, not the last cycle.

## Test plan
- Reset, then en=1 with q_in=5,6,7,8 on consecutive edges (LOCK_N=3):
  - locked=1 and dir=1 after the 4th edge.
  - err=0 and rev=0 throughout.
- Locked up at 14, then q_in=15,0,1:
  - Stays locked; no err (wrap accepted).
- Locked up at 9, then q_in=8:
  - rev pulses once; dir=0; locked stays 1.
  - Next q_in=7 → no pulse.
- Locked up at 3, then q_in=3 (stall), then q_in=10:
  - err pulses on the stall sample; err_cnt=1; locked=0.
  - The 10 produces no err and leaves run=0.
- ERR_W=2: force 5 lock/error cycles:
  - err_cnt reads 1,2,3,3,3.
  - err pulses all 5 times.
- Locked state, assert rst together with en=1 and q_in=12:
  - All outputs at reset values next cycle.
  - Following q_in=13,14,15 (en=1) → no lock yet. 12 was not sampled, so 13 is the first sample and 3 further steps are required.

Source files
------------

// File: rtl/updown_count_checker.sv
// updown_count_checker: locks onto a ±1 counter stream (clk, rst, en, q_in -> dir, locked, err, rev, err_cnt)
module updown_count_checker #(
  parameter int W      = 4,
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     q_in,
  output logic             dir,
  output logic             locked,
  output logic             err,
  output logic             rev,
  output logic [ERR_W-1:0] err_cnt
);
  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] ACQ     = 2'd1;
  localparam logic [1:0] LOCK    = 2'd2;
  localparam logic [3:0] RUN_MAX = 4'(LOCK_N);
  logic [1:0]   state;
  logic [W-1:0] prev;
  logic [W-1:0] delta;
  logic [3:0]   run;
  logic [3:0]   run_nxt;
  logic         up;
  logic         dn;
  logic         step;
  logic         same;
  assign delta   = q_in - prev;
  assign up      = delta == W'(1);
  assign dn      = delta == {W{1'b1}};
  assign step    = up | dn;
  assign same    = up == dir;
  assign run_nxt = (run != 4'd0 && same) ? ((run == RUN_MAX) ? RUN_MAX : run + 4'd1) : 4'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      prev    <= '0;
      run     <= '0;
      dir     <= 1'b1;
      locked  <= 1'b0;
      err     <= 1'b0;
      rev     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= 1'b0;
      rev <= 1'b0;
      if (en) begin
        prev <= q_in;
        case (state)
          EMPTY: begin
            state <= ACQ;
            run   <= '0;
          end
          ACQ: begin
            if (step) begin
              run <= run_nxt;
              dir <= up;
              if (run_nxt == RUN_MAX) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              run <= '0;
            end
          end
          LOCK: begin
            if (step) begin
              if (!same) begin
                dir <= up;
                rev <= 1'b1;
              end
            end else begin
              err     <= 1'b1;
              err_cnt <= &err_cnt ? err_cnt : err_cnt + 1'b1;
              locked  <= 1'b0;
              run     <= '0;
              state   <= ACQ;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_updown_count_checker.sv
// tb_updown_count_checker: scoreboard bench for updown_count_checker
module tb_updown_count_checker;
  typedef struct packed {
    logic       dir;
    logic       locked;
    logic       err;
    logic       rev;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] q_in = 4'd0;
  logic       dir, locked, err, rev;
  logic [7:0] err_cnt;
  logic       dir2, locked2, err2, rev2;
  logic [1:0] err_cnt2;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  exp_t       e;
  int         ms, mr, mc;
  logic [3:0] mp;
  logic       md, ml, me, mrv;

  updown_count_checker #(.W(4), .LOCK_N(3), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in),
    .dir(dir), .locked(locked), .err(err), .rev(rev), .err_cnt(err_cnt)
  );
  updown_count_checker #(.W(4), .LOCK_N(3), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in),
    .dir(dir2), .locked(locked2), .err(err2), .rev(rev2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  function automatic exp_t got();
    return '{dir, locked, err, rev, err_cnt, err_cnt2};
  endfunction

  task automatic model(input logic r, input logic en_s, input logic [3:0] q);
    logic [3:0] d;
    logic up, dn;
    if (r) begin
      ms = 0; mr = 0; mc = 0; mp = 0; md = 1; ml = 0; me = 0; mrv = 0;
    end else begin
      me = 0;
      mrv = 0;
      if (en_s) begin
        d = q - mp;
        up = d == 4'd1;
        dn = d == 4'hF;
        if (ms == 0) begin
          ms = 1;
          mr = 0;
        end else if (ms == 1) begin
          if (up || dn) begin
            if (mr > 0 && up == md) mr = (mr < 3) ? mr + 1 : 3;
            else begin md = up; mr = 1; end
            if (mr == 3) begin ms = 2; ml = 1; end
          end else mr = 0;
        end else begin
          if (up || dn) begin
            if (up != md) begin md = up; mrv = 1; end
          end else begin
            me = 1; mc++; ml = 0; mr = 0; ms = 1;
          end
        end
        mp = q;
      end
    end
    sb.push_back('{md, ml, me, mrv, 8'(mc > 255 ? 255 : mc), 2'(mc > 3 ? 3 : mc)});
  endtask

  task automatic cycle(input logic r, input logic en_s, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    en = en_s;
    q_in = q;
    model(r, en_s, q);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0);
    e = sb.pop_front();
    checks++;
    if (got() !== e) begin errors++; $display("FAIL reset_sb got %h exp %h", got(), e); end
    checks++;
    if (got() !== 14'b1000_0000_0000_00) begin errors++; $display("FAIL reset_vals got %h exp %h", got(), 14'b1000_0000_0000_00); end
  endtask

  task automatic test_lock();
    logic [3:0] seq[4] = '{5, 6, 7, 8};
    foreach (seq[i]) begin
      cycle(0, 1, seq[i]);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin errors++; $display("FAIL lock_sb[%0d] got %h exp %h", i, got(), e); end
      checks++;
      if (err !== 1'b0 || rev !== 1'b0) begin errors++; $display("FAIL lock_pulse[%0d] got err=%b rev=%b exp 0 0", i, err, rev); end
    end
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1) begin errors++; $display("FAIL lock_up got locked=%b dir=%b exp 1 1", locked, dir); end
  endtask

  task automatic test_wrap();
    logic [3:0] seq[9] = '{9, 10, 11, 12, 13, 14, 15, 0, 1};
    foreach (seq[i]) begin
      cycle(0, 1, seq[i]);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin errors++; $display("FAIL wrap_sb[%0d] got %h exp %h", i, got(), e); end
      checks++;
      if (locked !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wrap[%0d] got locked=%b err=%b exp 1 0", i, locked, err); end
    end
  endtask

  task automatic test_reverse();
    logic [3:0] seq[6] = '{6, 7, 8, 9, 8, 7};
    cycle(1, 0, 0);
    void'(sb.pop_front());
    foreach (seq[i]) begin
      cycle(0, 1, seq[i]);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin errors++; $display("FAIL rev_sb[%0d] got %h exp %h", i, got(), e); end
      if (i == 4) begin
        checks++;
        if (rev !== 1'b1 || dir !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL rev_pulse got rev=%b dir=%b locked=%b exp 1 0 1", rev, dir, locked); end
      end
      if (i == 5) begin
        checks++;
        if (rev !== 1'b0 || dir !== 1'b0) begin errors++; $display("FAIL rev_once got rev=%b dir=%b exp 0 0", rev, dir); end
      end
    end
  endtask

  task automatic test_error();
    logic [3:0] seq[6] = '{0, 1, 2, 3, 3, 10};
    cycle(1, 0, 0);
    void'(sb.pop_front());
    foreach (seq[i]) begin
      cycle(0, 1, seq[i]);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin errors++; $display("FAIL err_sb[%0d] got %h exp %h", i, got(), e); end
      if (i == 4) begin
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin errors++; $display("FAIL err_stall got err=%b cnt=%0d locked=%b exp 1 1 0", err, err_cnt, locked); end
      end
      if (i == 5) begin
        checks++;
        if (err !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL err_jump_acq got err=%b locked=%b exp 0 0", err, locked); end
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] v = 4'd3;
    logic [1:0] want2;
    cycle(1, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 4'(i));
      void'(sb.pop_front());
    end
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, v);
      e = sb.pop_front();
      want2 = (k >= 2) ? 2'd3 : 2'(k + 1);
      checks++;
      if (got() !== e) begin errors++; $display("FAIL sat_sb[%0d] got %h exp %h", k, got(), e); end
      checks++;
      if (err2 !== 1'b1 || err_cnt2 !== want2 || err_cnt !== 8'(k + 1)) begin
        errors++; $display("FAIL sat[%0d] got err=%b cnt2=%0d cnt8=%0d exp 1 %0d %0d", k, err2, err_cnt2, err_cnt, want2, k + 1);
      end
      for (int j = 1; j <= 3; j++) begin
        cycle(0, 1, v + 4'(j));
        void'(sb.pop_front());
      end
      v = v + 4'd3;
      checks++;
      if (locked2 !== 1'b1) begin errors++; $display("FAIL sat_relock[%0d] got %b exp 1", k, locked2); end
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [3:0] seq[3] = '{13, 14, 15};
    cycle(1, 0, 0);
    void'(sb.pop_front());
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 1, 4'(i));
      void'(sb.pop_front());
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL rst_pre_lock got %b exp 1", locked); end
    cycle(1, 1, 12);
    e = sb.pop_front();
    checks++;
    if (got() !== 14'b1000_0000_0000_00 || got() !== e) begin errors++; $display("FAIL rst_mid_lock got %h exp %h", got(), e); end
    foreach (seq[i]) begin
      cycle(0, 1, seq[i]);
      e = sb.pop_front();
      checks++;
      if (got() !== e || locked !== 1'b0) begin errors++; $display("FAIL rst_relock[%0d] got %h exp %h", i, got(), e); end
    end
  endtask

  task automatic test_gap();
    cycle(1, 0, 0);
    void'(sb.pop_front());
    cycle(0, 1, 1); void'(sb.pop_front());
    cycle(0, 1, 2); void'(sb.pop_front());
    cycle(0, 0, 9);
    e = sb.pop_front();
    checks++;
    if (got() !== e) begin errors++; $display("FAIL gap_idle got %h exp %h", got(), e); end
    cycle(0, 1, 3); void'(sb.pop_front());
    cycle(0, 0, 9); void'(sb.pop_front());
    cycle(0, 1, 4);
    e = sb.pop_front();
    checks++;
    if (got() !== e || locked !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL gap_lock got %h exp %h", got(), e); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq[6] = '{1, 0, 15, 14, 9, 2};
    cycle(1, 0, 0);
    void'(sb.pop_front());
    foreach (seq[i]) begin
      cycle(0, 1, seq[i]);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin errors++; $display("FAIL b2b_sb[%0d] got %h exp %h", i, got(), e); end
      if (i == 3) begin
        checks++;
        if (locked !== 1'b1 || dir !== 1'b0) begin errors++; $display("FAIL b2b_down_lock got locked=%b dir=%b exp 1 0", locked, dir); end
      end
      if (i == 5) begin
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd1) begin errors++; $display("FAIL b2b_second got err=%b cnt=%0d exp 0 1", err, err_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_reverse();
    test_error();
    test_saturate();
    test_reset_mid_lock();
    test_gap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
